// File: rtl/spi_master.sv
// spi_master: full-duplex SPI master, one DATA_W-bit frame per start request.
// Supports all four CPOL/CPHA modes, a programmable SCLK divider, and a
// guaranteed CS-high gap between frames.
// Optional feature macro: SPI_MASTER_RX_EN
//   defined   - spi_miso is sampled and rx_data returns the received frame
//   undefined - the receive path is not built; rx_data is tied to zero
`timescale 1ns/1ps

module spi_master #(
  parameter int unsigned DATA_W  = 8,   // frame width in bits (>= 2)
  parameter int unsigned CLK_DIV = 16,  // clk cycles per SCLK half-period (>= 1)
  parameter int unsigned CPOL    = 0,   // SCLK idle level
  parameter int unsigned CPHA    = 0,   // 0: sample leading edge, 1: sample trailing edge
  parameter int unsigned CS_GAP  = 2    // clk cycles CS stays high after a frame (>= 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
  localparam int unsigned GAP_W  = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_FINAL = EDGE_W'(2 * DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(CS_GAP - 1);
  localparam logic              IDLE_CLK   = 1'(CPOL);
  localparam logic              SAMPLE_PAR = 1'(CPHA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;     // number of SCLK edges already produced
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic                clk_q, clk_d;
  logic                mosi_q, mosi_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;             // start taken this cycle
  logic                sclk_edge;          // an SCLK edge happens this cycle
  logic                leave_trail;        // frame ends this cycle

  // Next-state logic for the frame sequencer and the transmit path.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    div_d       = div_q;
    edge_d      = edge_q;
    gap_d       = gap_q;
    tx_sh_d     = tx_sh_q;
    clk_d       = clk_q;
    mosi_d      = mosi_q;
    cs_d        = cs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    sclk_edge   = 1'b0;
    leave_trail = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end

      // CS setup time; the first SCLK edge fires as LEAD expires.
      S_LEAD: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          sclk_edge = 1'b1;
          state_d   = S_SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          sclk_edge = 1'b1;
          if (edge_q == EDGE_FINAL) state_d = S_TRAIL;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_TRAIL: begin
        if (div_q == DIV_LAST) begin
          div_d       = '0;
          leave_trail = 1'b1;
          cs_d        = 1'b1;
          done_d      = 1'b1;
          gap_d       = '0;
          state_d     = S_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      // CS-high gap; a start seen on its last cycle chains straight into
      // the next frame so back-to-back traffic has no extra bubble.
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (start) begin
            accept = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_LEAD;
      tx_sh_d = tx_data;
      cs_d    = 1'b0;
      busy_d  = 1'b1;
      div_d   = '0;
      edge_d  = '0;
      // Leading-edge samplers need the MSB on the wire before the first edge.
      if (CPHA == 0) mosi_d = tx_data[DATA_W-1];
    end

    if (sclk_edge) begin
      edge_d = edge_q + EDGE_W'(1);
      clk_d  = ~clk_q;
      if (CPHA == 0) begin
        // edge_q odd means this is an even (trailing) edge: shift out next bit,
        // except on the final edge where there is nothing left to send.
        if (edge_q[0] && (edge_q != EDGE_FINAL)) begin
          mosi_d  = tx_sh_q[DATA_W-2];
          tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
      end else begin
        // edge_q even means this is an odd (leading) edge: drive a bit.
        if (!edge_q[0]) begin
          mosi_d  = tx_sh_q[DATA_W-1];
          tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      gap_q   <= '0;
      tx_sh_q <= '0;
      clk_q   <= IDLE_CLK;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      gap_q   <= gap_d;
      tx_sh_q <= tx_sh_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  // Receive shifter: samples on odd edges for CPHA=0, even edges for CPHA=1,
  // first bit ends up in the MSB; result is published as the frame ends.
  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    if (sclk_edge && (edge_q[0] == SAMPLE_PAR)) begin
      rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso};
    end
    if (leave_trail) rx_data_d = rx_sh_q;
  end

  // Receive registers.
  always_ff @(posedge clk) begin
    // NOTE: the receive shifter is reset along with everything else; it is
    // fully overwritten each frame, but a known value keeps rx_data clean.
    if (rst) begin
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
`else
  // Receive path not built: spi_miso is deliberately left unconnected.
  logic unused_miso;
  logic unused_par;
  assign unused_miso = spi_miso;
  assign unused_par  = SAMPLE_PAR;
  assign rx_data     = '0;
`endif

  assign spi_clk  = clk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs   = cs_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master. Four instances cover mode 0, mode 3,
// a 16-bit CLK_DIV=1 build and the default configuration. Expected receive
// data depends on whether SPI_MASTER_RX_EN is defined.
`timescale 1ns/1ps

module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  start_v, busy_v, done_v, cs_v, sclk_v, mosi_v, miso_v;
  logic [15:0] tx_a [4];
  logic [7:0]  rx0, rx1, rx3;
  logic [15:0] rx2;

  // Slave-side capture of MOSI on every rising SCLK while CS is low.
  logic [15:0] cap   [4] = '{default: 16'h0};
  int          cap_n [4] = '{default: 0};
  logic [3:0]  cs_prev = 4'hF;
  logic [7:0]  slave_word = 8'hC3;

  int tests = 0;
  int fails = 0;

  // Loopback for instances 0, 2, 3; instance 1 gets data from a slave model
  // that presents the next bit of slave_word after every rising SCLK.
  assign miso_v[0] = mosi_v[0];
  assign miso_v[2] = mosi_v[2];
  assign miso_v[3] = mosi_v[3];
  assign miso_v[1] = (cap_n[1] < 8) ? slave_word[3'(7 - cap_n[1])] : 1'b0;

  spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .CS_GAP(2)) u_m0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .tx_data(tx_a[0][7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .rx_data(rx0), .spi_clk(sclk_v[0]),
    .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0]), .spi_cs(cs_v[0]));

  spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .CS_GAP(2)) u_m3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .tx_data(tx_a[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .rx_data(rx1), .spi_clk(sclk_v[1]),
    .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1]), .spi_cs(cs_v[1]));

  spi_master #(.DATA_W(16), .CLK_DIV(1), .CPOL(0), .CPHA(0), .CS_GAP(3)) u_w16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .tx_data(tx_a[2]),
    .busy(busy_v[2]), .done(done_v[2]), .rx_data(rx2), .spi_clk(sclk_v[2]),
    .spi_mosi(mosi_v[2]), .spi_miso(miso_v[2]), .spi_cs(cs_v[2]));

  spi_master u_def (
    .clk(clk), .rst(rst), .start(start_v[3]), .tx_data(tx_a[3][7:0]),
    .busy(busy_v[3]), .done(done_v[3]), .rx_data(rx3), .spi_clk(sclk_v[3]),
    .spi_mosi(mosi_v[3]), .spi_miso(miso_v[3]), .spi_cs(cs_v[3]));

  for (genvar g = 0; g < 4; g++) begin : g_cap
    always @(posedge sclk_v[g] or cs_v[g]) begin
      if (cs_v[g] !== cs_prev[g]) begin
        if (cs_v[g] === 1'b0) begin
          cap[g]   = 16'h0;
          cap_n[g] = 0;
        end
        cs_prev[g] = cs_v[g];
      end else if (cs_v[g] === 1'b0) begin
        cap[g]   = {cap[g][14:0], mosi_v[g]};
        cap_n[g] = cap_n[g] + 1;
      end
    end
  end

  // Mode 3 must only move MOSI together with a falling SCLK.
  int   viol = 0;
  logic prev_m1 = 1'b0;
  always @(negedge clk) begin
    if (cs_v[1] === 1'b0 && mosi_v[1] !== prev_m1 && sclk_v[1] !== 1'b0) viol++;
    prev_m1 = mosi_v[1];
  end

  // Per-frame trackers, updated by step().
  int          lat, done_cnt, first_done, last_done, busy_low;
  logic [15:0] cap_first;
  logic        cs_at_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rx_of(input int idx);
    case (idx)
      0:       return {8'h00, rx0};
      1:       return {8'h00, rx1};
      2:       return rx2;
      default: return {8'h00, rx3};
    endcase
  endfunction

  function automatic logic [15:0] rx_exp(input logic [15:0] v);
`ifdef SPI_MASTER_RX_EN
    return v;
`else
    return (v & 16'h0000);
`endif
  endfunction

  // Issue a start for one clk; returns just after edge T0 with lat = 0.
  task automatic launch(input int idx, input logic [15:0] data);
    done_cnt   = 0;
    first_done = -1;
    last_done  = -1;
    busy_low   = -1;
    cap_first  = 16'h0;
    cs_at_done = 1'b0;
    @(negedge clk);
    tx_a[idx]    = data;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    lat          = 0;
    start_v[idx] = 1'b0;
  endtask

  // Advance one clk and record done / busy events relative to T0.
  task automatic step(input int idx);
    @(posedge clk);
    #1;
    lat++;
    if (done_v[idx] === 1'b1) begin
      done_cnt++;
      if (first_done < 0) begin
        first_done = lat;
        cap_first  = cap[idx];
        cs_at_done = cs_v[idx];
      end
      last_done = lat;
    end
    if (busy_v[idx] === 1'b0 && busy_low < 0) busy_low = lat;
  endtask

  task automatic run_to_idle(input int idx, input int budget);
    while (busy_low < 0 && lat < budget) step(idx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start_v = 4'h0;
    for (int i = 0; i < 4; i++) tx_a[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs",    cs_v,   4'hF);
    check("rst_sclk",  sclk_v, 4'b0010);
    check("rst_mosi",  mosi_v, 4'h0);
    check("rst_busy",  busy_v, 4'h0);
    check("rst_done",  done_v, 4'h0);
    check("rst_rx8",   {rx0, rx1, rx3}, 24'h0);
    check("rst_rx16",  rx2, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, loopback 0xA5.
    launch(0, 16'h00A5);
    check("m0_cs_fall", cs_v[0], 1'b0);
    check("m0_busy_t0", busy_v[0], 1'b1);
    check("m0_msb_t0",  mosi_v[0], 1'b1);
    run_to_idle(0, 200);
    check("m0_done_at",  first_done, 34);
    check("m0_cs_done",  cs_at_done, 1'b1);
    check("m0_busy_low", busy_low, 36);
    check("m0_done_cnt", done_cnt, 1);
    check("m0_mosi_bits", cap_first, 16'h00A5);
    check("m0_rx",       rx_of(0), rx_exp(16'h00A5));
    check("m0_sclk_idle", sclk_v[0], 1'b0);
    check("m0_mosi_hold", mosi_v[0], 1'b1);

    // Mode 3, tx 0x3C, slave returns 0xC3.
    launch(1, 16'h003C);
    check("m3_sclk_t0", sclk_v[1], 1'b1);
    run_to_idle(1, 200);
    check("m3_done_at",   first_done, 34);
    check("m3_busy_low",  busy_low, 36);
    check("m3_mosi_bits", cap_first, 16'h003C);
    check("m3_mosi_fall", viol, 0);
    check("m3_rx",        rx_of(1), rx_exp(16'h00C3));
    check("m3_sclk_idle", sclk_v[1], 1'b1);

    // 16-bit, CLK_DIV=1, CS_GAP=3, single frame.
    launch(2, 16'hBEEF);
    run_to_idle(2, 200);
    check("w16_done_at",   first_done, 33);
    check("w16_busy_low",  busy_low, 36);
    check("w16_mosi_bits", cap_first, 16'hBEEF);
    check("w16_rx",        rx_of(2), rx_exp(16'hBEEF));

    // 16-bit with start held: the next frame chains in at T0+36.
    launch(2, 16'hBEEF);
    start_v[2] = 1'b1;
    while (busy_low < 0 && lat < 300) begin
      step(2);
      if (lat == 1) tx_a[2] = 16'h1234;
      if (lat == 35) check("w16_cs_gap", cs_v[2], 1'b1);
      if (lat == 36) begin
        check("w16_cs_refall", cs_v[2], 1'b0);
        check("w16_busy_held", busy_v[2], 1'b1);
        start_v[2] = 1'b0;
      end
    end
    check("w16b_first_bits", cap_first, 16'hBEEF);
    check("w16b_done_cnt",   done_cnt, 2);
    check("w16b_done2_at",   last_done, 69);
    check("w16b_busy_low",   busy_low, 72);
    check("w16b_bits2",      cap[2], 16'h1234);
    check("w16b_rx",         rx_of(2), rx_exp(16'h1234));

    // Mode 0 with starts while busy and a tx_data change mid-frame.
    launch(0, 16'h00A5);
    while (busy_low < 0 && lat < 200) begin
      step(0);
      if (lat == 4) begin
        start_v[0] = 1'b1;
        tx_a[0]    = 16'h0000;
      end
      if (lat == 5) start_v[0] = 1'b0;
      if (lat == 34) start_v[0] = 1'b1;
      if (lat == 35) start_v[0] = 1'b0;
    end
    check("ign_done_cnt",  done_cnt, 1);
    check("ign_done_at",   first_done, 34);
    check("ign_busy_low",  busy_low, 36);
    check("ign_mosi_bits", cap_first, 16'h00A5);
    check("ign_rx",        rx_of(0), rx_exp(16'h00A5));
    repeat (3) step(0);
    check("ign_no_queue",  {busy_v[0], cs_v[0]}, 2'b01);

    // Mode 0, loopback 0xFF.
    launch(0, 16'h00FF);
    run_to_idle(0, 200);
    check("ff_done_at", first_done, 34);
    check("ff_rx",      rx_of(0), rx_exp(16'h00FF));

    // Default build: reset at T0+40 aborts, then a fresh frame completes.
    launch(3, 16'h005A);
    while (lat < 39) step(3);
    rst = 1'b1;
    step(3);
    check("abort_cs",   cs_v[3], 1'b1);
    check("abort_sclk", sclk_v[3], 1'b0);
    check("abort_mosi", mosi_v[3], 1'b0);
    check("abort_busy", busy_v[3], 1'b0);
    check("abort_done", done_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    launch(3, 16'h0096);
    run_to_idle(3, 400);
    check("def_done_at",   first_done, 272);
    check("def_busy_low",  busy_low, 274);
    check("def_done_cnt",  done_cnt, 1);
    check("def_mosi_bits", cap_first, 16'h0096);
    check("def_rx",        rx_of(3), rx_exp(16'h0096));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
